// File: rtl/store_checker.sv
// -----------------------------------------------------------------------------
// store_checker
//   Snoops the data-memory write bus of the MIPS top level and checks the
//   observed stores against a loaded table of NCHK expected (address, data)
//   pairs. Reports PASS or FAIL with an error code, and captures the offending
//   store. A run times out after TIMEOUT cycles. With ORDERED=1 the entries
//   must be hit in ascending index order.
//
// Ports
//   clk         rising-edge system clock
//   reset       asynchronous, active-low reset
//   cfg_we      table write strobe (accepted in IDLE only)
//   cfg_idx     table entry index (index >= NCHK is ignored)
//   cfg_addr    expected store address for the entry
//   cfg_data    expected store data for the entry
//   start       IDLE -> RUN (ignored in other states)
//   clear       return to IDLE from any state; table contents are kept
//   memwrite    snooped store strobe
//   dataadr     snooped store address
//   writedata   snooped store data
//   done        state is PASS or FAIL
//   pass        state is PASS
//   fail        state is FAIL
//   err_code    0 none, 1 data mismatch, 2 order violation, 3 timeout
//   match_mask  bit i set when entry i matched during this run
//   fail_addr   address of the offending store (0 on timeout)
//   fail_data   data of the offending store (0 on timeout)
//   run_cycles  cycles spent in RUN, saturating at TIMEOUT
// -----------------------------------------------------------------------------
module store_checker #(
    parameter int N       = 32,
    parameter int A       = 32,
    parameter int NCHK    = 4,
    parameter int TIMEOUT = 1024,
    parameter int ORDERED = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [((NCHK > 1) ? $clog2(NCHK) : 1)-1:0] cfg_idx,
    input  logic [A-1:0]                  cfg_addr,
    input  logic [N-1:0]                  cfg_data,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          memwrite,
    input  logic [A-1:0]                  dataadr,
    input  logic [N-1:0]                  writedata,
    output logic                          done,
    output logic                          pass,
    output logic                          fail,
    output logic [1:0]                    err_code,
    output logic [NCHK-1:0]               match_mask,
    output logic [A-1:0]                  fail_addr,
    output logic [N-1:0]                  fail_data,
    output logic [$clog2(TIMEOUT+1)-1:0]  run_cycles
);

    localparam int IW = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] RC_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RC_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // Lowest set bit of a vector, as a one-hot vector (zero in, zero out).
    function automatic logic [NCHK-1:0] lowest_onehot(input logic [NCHK-1:0] v);
        logic [NCHK-1:0] r;
        r = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Lowest set bit of a vector, as an index (zero when the vector is empty).
    function automatic logic [IW-1:0] lowest_index(input logic [NCHK-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    state_t          state_r;
    logic [A-1:0]    tbl_addr_r [NCHK];
    logic [N-1:0]    tbl_data_r [NCHK];
    logic [NCHK-1:0] tbl_valid_r;
    logic [NCHK-1:0] match_mask_r;
    logic [IW-1:0]   ptr_r;
    logic [CW-1:0]   run_cycles_r;
    logic [1:0]      err_code_r;
    logic [A-1:0]    fail_addr_r;
    logic [N-1:0]    fail_data_r;
    logic            done_r;
    logic            pass_r;
    logic            fail_r;

    logic [NCHK-1:0] idx_onehot_s;
    logic            tbl_we_s;
    logic [NCHK-1:0] valid_eff_s;
    logic [NCHK-1:0] addr_hit_s;
    logic [NCHK-1:0] data_hit_s;
    logic [NCHK-1:0] ptr_onehot_s;
    logic [NCHK-1:0] above_ptr_s;
    logic [NCHK-1:0] unmatched_s;
    logic [NCHK-1:0] new_match_s;
    logic [NCHK-1:0] next_mask_s;
    logic            err_data_s;
    logic            err_order_s;
    logic            complete_s;
    logic [IW-1:0]   next_ptr_s;
    logic [IW-1:0]   start_ptr_s;

    // Table write decode and the valid set seen by a start on the same edge.
    always_comb begin
        idx_onehot_s = '0;
        for (int i = 0; i < NCHK; i++) begin
            idx_onehot_s[i] = (cfg_idx == IW'(i));
        end
        tbl_we_s = (state_r == ST_IDLE) && cfg_we && !clear && (|idx_onehot_s);
        if (tbl_we_s) begin
            valid_eff_s = tbl_valid_r | idx_onehot_s;
        end else begin
            valid_eff_s = tbl_valid_r;
        end
        start_ptr_s = lowest_index(valid_eff_s);
    end

    // Store classification against the table for the current RUN cycle.
    always_comb begin
        addr_hit_s   = '0;
        data_hit_s   = '0;
        ptr_onehot_s = '0;
        above_ptr_s  = '0;
        new_match_s  = '0;
        err_data_s   = 1'b0;
        err_order_s  = 1'b0;
        for (int i = 0; i < NCHK; i++) begin
            addr_hit_s[i]   = tbl_valid_r[i] && (tbl_addr_r[i] == dataadr);
            data_hit_s[i]   = addr_hit_s[i] && (tbl_data_r[i] == writedata);
            ptr_onehot_s[i] = (ptr_r == IW'(i));
            above_ptr_s[i]  = tbl_valid_r[i] && (IW'(i) > ptr_r);
        end
        unmatched_s = tbl_valid_r & ~match_mask_r;

        if (memwrite) begin
            if (ORDERED == 0) begin
                // A repeat of an already matched (addr,data) is harmless;
                // any other store to a table address must carry table data.
                if (|(data_hit_s & unmatched_s)) begin
                    new_match_s = lowest_onehot(data_hit_s & unmatched_s);
                end else if (|(data_hit_s & match_mask_r)) begin
                    new_match_s = '0;
                end else if (|addr_hit_s) begin
                    err_data_s = 1'b1;
                end else begin
                    new_match_s = '0;
                end
            end else begin
                // Only the entry under the pointer may match; touching any
                // other pending entry is an ordering violation.
                if (|(addr_hit_s & ptr_onehot_s & unmatched_s)) begin
                    if (|(data_hit_s & ptr_onehot_s)) begin
                        new_match_s = ptr_onehot_s;
                    end else begin
                        err_data_s = 1'b1;
                    end
                end else if (|(addr_hit_s & unmatched_s)) begin
                    err_order_s = 1'b1;
                end else begin
                    new_match_s = '0;
                end
            end
        end else begin
            new_match_s = '0;
        end

        next_mask_s = match_mask_r | new_match_s;
        complete_s  = ((next_mask_s & tbl_valid_r) == tbl_valid_r);
        next_ptr_s  = lowest_index(above_ptr_s);
    end

    // Expected-store table storage; only the valid bits need a reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCHK; i++) begin
            if (tbl_we_s && idx_onehot_s[i]) begin
                tbl_addr_r[i] <= cfg_addr;
                tbl_data_r[i] <= cfg_data;
            end
        end
    end

    // Checker state machine with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            tbl_valid_r  <= '0;
            match_mask_r <= '0;
            ptr_r        <= '0;
            run_cycles_r <= '0;
            err_code_r   <= 2'd0;
            fail_addr_r  <= '0;
            fail_data_r  <= '0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
        end else if (clear) begin
            state_r      <= ST_IDLE;
            match_mask_r <= '0;
            ptr_r        <= '0;
            run_cycles_r <= '0;
            err_code_r   <= 2'd0;
            fail_addr_r  <= '0;
            fail_data_r  <= '0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tbl_valid_r <= valid_eff_s;
                    if (start) begin
                        match_mask_r <= '0;
                        run_cycles_r <= '0;
                        ptr_r        <= start_ptr_s;
                        if (valid_eff_s == '0) begin
                            state_r <= ST_PASS;
                            pass_r  <= 1'b1;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (run_cycles_r != RC_MAX) begin
                        run_cycles_r <= run_cycles_r + CW'(1);
                    end
                    match_mask_r <= next_mask_s;
                    if (|new_match_s) begin
                        ptr_r <= next_ptr_s;
                    end
                    // Completion outranks the timeout in the same cycle.
                    if (complete_s) begin
                        state_r <= ST_PASS;
                        pass_r  <= 1'b1;
                        done_r  <= 1'b1;
                    end else if (err_data_s || err_order_s) begin
                        state_r     <= ST_FAIL;
                        fail_r      <= 1'b1;
                        done_r      <= 1'b1;
                        err_code_r  <= err_data_s ? 2'd1 : 2'd2;
                        fail_addr_r <= dataadr;
                        fail_data_r <= writedata;
                    end else if (run_cycles_r == RC_LAST) begin
                        state_r    <= ST_FAIL;
                        fail_r     <= 1'b1;
                        done_r     <= 1'b1;
                        err_code_r <= 2'd3;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    // Sticky until clear or reset.
                    state_r <= state_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign done       = done_r;
    assign pass       = pass_r;
    assign fail       = fail_r;
    assign err_code   = err_code_r;
    assign match_mask = match_mask_r;
    assign fail_addr  = fail_addr_r;
    assign fail_data  = fail_data_r;
    assign run_cycles = run_cycles_r;

endmodule

// File: tb/tb_store_checker.sv
// -----------------------------------------------------------------------------
// tb_store_checker
//   Two store_checker instances (unordered and ordered, NCHK=4, TIMEOUT=16)
//   share one stimulus stream. A reference model predicts each run's outcome
//   from the table and the list of stores; predictions go into per-instance
//   queues and a monitor compares them when done rises.
// -----------------------------------------------------------------------------
module tb_store_checker;

    localparam int NC = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic        ps;
        logic        fl;
        logic [1:0]  err;
        logic [3:0]  mask;
        logic [31:0] fa;
        logic [31:0] fd;
        logic [4:0]  rc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, cfg_we, start, clear, memwrite;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr, cfg_data, dataadr, writedata;
    logic [1:0]  done, pass, fail;
    logic [1:0]  err_code   [2];
    logic [3:0]  match_mask [2];
    logic [31:0] fail_addr  [2];
    logic [31:0] fail_data  [2];
    logic [4:0]  run_cycles [2];

    int nvec = 0;
    int nbad = 0;

    bit          tv [NC];
    logic [31:0] ta [NC];
    logic [31:0] td [NC];
    bit          st_we [$];
    logic [31:0] st_a  [$];
    logic [31:0] st_d  [$];
    bit          same_edge;
    bit          cfg_noise;
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        last_e [2];
    logic [1:0]  prev_done = 2'b00;

    always #5 clk = ~clk;

    store_checker #(.N(32), .A(32), .NCHK(NC), .TIMEOUT(TO), .ORDERED(0)) u0 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done[0]), .pass(pass[0]), .fail(fail[0]), .err_code(err_code[0]),
        .match_mask(match_mask[0]), .fail_addr(fail_addr[0]),
        .fail_data(fail_data[0]), .run_cycles(run_cycles[0]));

    store_checker #(.N(32), .A(32), .NCHK(NC), .TIMEOUT(TO), .ORDERED(1)) u1 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done[1]), .pass(pass[1]), .fail(fail[1]), .err_code(err_code[1]),
        .match_mask(match_mask[1]), .fail_addr(fail_addr[1]),
        .fail_data(fail_data[1]), .run_cycles(run_cycles[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome of one run, derived from the checking rules over the whole store list.
    function automatic exp_t model(input bit ordered);
        exp_t        e;
        bit          m [NC];
        bit          fin, any, rep, allm, anyv;
        int          hit, nxt;
        logic [31:0] a, d;
        e    = '0;
        fin  = 1'b0;
        anyv = 1'b0;
        for (int i = 0; i < NC; i++) begin
            m[i] = 1'b0;
            anyv = anyv | tv[i];
        end
        if (!anyv) begin
            e.ps = 1'b1;
            return e;
        end
        for (int k = 0; k < TO && !fin; k++) begin
            if (k < st_we.size() && st_we[k]) begin
                a = st_a[k];
                d = st_d[k];
                if (!ordered) begin
                    hit = -1;
                    for (int i = 0; i < NC; i++)
                        if (hit < 0 && tv[i] && !m[i] && ta[i] == a && td[i] == d) hit = i;
                    if (hit >= 0) begin
                        m[hit] = 1'b1;
                    end else begin
                        any = 1'b0;
                        rep = 1'b0;
                        for (int i = 0; i < NC; i++) begin
                            if (tv[i] && ta[i] == a) begin
                                any = 1'b1;
                                if (td[i] == d) rep = 1'b1;
                            end
                        end
                        if (any && !rep) begin
                            e.fl = 1'b1; e.err = 2'd1; e.fa = a; e.fd = d; fin = 1'b1;
                        end
                    end
                end else begin
                    nxt = -1;
                    any = 1'b0;
                    for (int i = 0; i < NC; i++) begin
                        if (nxt < 0 && tv[i] && !m[i]) nxt = i;
                        if (tv[i] && !m[i] && ta[i] == a) any = 1'b1;
                    end
                    if (ta[nxt] == a) begin
                        if (td[nxt] == d) m[nxt] = 1'b1;
                        else begin e.fl = 1'b1; e.err = 2'd1; e.fa = a; e.fd = d; fin = 1'b1; end
                    end else if (any) begin
                        e.fl = 1'b1; e.err = 2'd2; e.fa = a; e.fd = d; fin = 1'b1;
                    end
                end
            end
            if (!fin) begin
                allm = 1'b1;
                for (int i = 0; i < NC; i++) if (tv[i] && !m[i]) allm = 1'b0;
                if (allm) begin
                    e.ps = 1'b1; fin = 1'b1;
                end else if (k == TO - 1) begin
                    e.fl = 1'b1; e.err = 2'd3; fin = 1'b1;
                end
            end
            if (fin) e.rc = 5'(k + 1);
        end
        for (int i = 0; i < NC; i++) e.mask[i] = m[i];
        return e;
    endfunction

    // Monitor: compare a prediction whenever an instance raises done.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (done[g] && !prev_done[g]) begin
                if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                    check($sformatf("unexpected_done[%0d]", g), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    if (g == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("pass[%0d]", g),       {31'd0, pass[g]},       {31'd0, e.ps});
                    check($sformatf("fail[%0d]", g),       {31'd0, fail[g]},       {31'd0, e.fl});
                    check($sformatf("err_code[%0d]", g),   {30'd0, err_code[g]},   {30'd0, e.err});
                    check($sformatf("match_mask[%0d]", g), {28'd0, match_mask[g]}, {28'd0, e.mask});
                    check($sformatf("fail_addr[%0d]", g),  fail_addr[g],           e.fa);
                    check($sformatf("fail_data[%0d]", g),  fail_data[g],           e.fd);
                    check($sformatf("run_cycles[%0d]", g), {27'd0, run_cycles[g]}, {27'd0, e.rc});
                end
            end
        end
        prev_done <= done;
    end

    task automatic clear_stim();
        for (int i = 0; i < NC; i++) begin
            tv[i] = 1'b0; ta[i] = 32'd0; td[i] = 32'd0;
        end
        st_we.delete(); st_a.delete(); st_d.delete();
        same_edge = 1'b0;
        cfg_noise = 1'b0;
    endtask

    task automatic add_st(input bit we, input logic [31:0] a, input logic [31:0] d);
        st_we.push_back(we); st_a.push_back(a); st_d.push_back(d);
    endtask

    task automatic check_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_done[%0d]", tag, g),       {31'd0, done[g]},       32'd0);
            check($sformatf("%s_err[%0d]", tag, g),        {30'd0, err_code[g]},   32'd0);
            check($sformatf("%s_mask[%0d]", tag, g),       {28'd0, match_mask[g]}, 32'd0);
            check($sformatf("%s_fail_addr[%0d]", tag, g),  fail_addr[g],           32'd0);
            check($sformatf("%s_fail_data[%0d]", tag, g),  fail_data[g],           32'd0);
            check($sformatf("%s_run_cycles[%0d]", tag, g), {27'd0, run_cycles[g]}, 32'd0);
        end
    endtask

    // One complete run: reset, load table, start, stores, outcome, sticky, clear.
    task automatic run_test();
        int vl [$];
        int cnt;
        @(negedge clk); reset = 1'b0;
        #1 check_zero("reset");
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < NC; i++) if (tv[i]) vl.push_back(i);
        for (int j = 0; j < vl.size(); j++) begin
            if (same_edge && j == vl.size() - 1) break;
            @(negedge clk);
            cfg_we = 1'b1; cfg_idx = 2'(vl[j]); cfg_addr = ta[vl[j]]; cfg_data = td[vl[j]];
        end
        @(negedge clk);
        start = 1'b1;
        if (same_edge && vl.size() > 0) begin
            cfg_we = 1'b1; cfg_idx = 2'(vl[vl.size()-1]);
            cfg_addr = ta[vl[vl.size()-1]]; cfg_data = td[vl[vl.size()-1]];
        end else begin
            cfg_we = 1'b0;
        end
        last_e[0] = model(1'b0);
        last_e[1] = model(1'b1);
        q0.push_back(last_e[0]);
        q1.push_back(last_e[1]);
        for (int k = 0; k < st_we.size(); k++) begin
            @(negedge clk);
            start = 1'b0;
            cfg_we = cfg_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            cfg_idx = 2'($urandom_range(0, 3)); cfg_addr = $urandom; cfg_data = $urandom;
            memwrite = st_we[k]; dataadr = st_a[k]; writedata = st_d[k];
        end
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0; memwrite = 1'b0;
        cnt = 0;
        while (done != 2'b11 && cnt < TO + 4) begin
            @(negedge clk);
            cnt++;
        end
        check("done_within_budget", {30'd0, done}, 32'd3);
        // start is ignored in PASS/FAIL and the results stay frozen.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("sticky_done[%0d]", g), {31'd0, done[g]}, 32'd1);
            check($sformatf("sticky_pass[%0d]", g), {31'd0, pass[g]}, {31'd0, last_e[g].ps});
            check($sformatf("sticky_mask[%0d]", g), {28'd0, match_mask[g]}, {28'd0, last_e[g].mask});
            check($sformatf("sticky_rc[%0d]", g),   {27'd0, run_cycles[g]}, {27'd0, last_e[g].rc});
        end
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check_zero("clear");
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
    endtask

    task automatic random_test();
        int          mode, len, cur, r, i;
        int          vl [$];
        clear_stim();
        for (int j = 0; j < NC; j++) begin
            tv[j] = ($urandom_range(0, 3) != 0);
            ta[j] = {22'd0, 6'($urandom_range(0, 63)), 2'(j), 2'b00};
            td[j] = $urandom;
            if (tv[j]) vl.push_back(j);
        end
        same_edge = 1'($urandom_range(0, 1));
        cfg_noise = 1'b1;
        mode = $urandom_range(0, 2);
        len  = $urandom_range(1, 14);
        cur  = 0;
        for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 99);
            if (vl.size() == 0 || (r >= 10 && r < 20)) begin
                add_st(1'b1, 32'h8000_0000 | 32'($urandom_range(0, 65535)), $urandom);
            end else begin
                i = vl[$urandom_range(0, vl.size() - 1)];
                if (r < 10) begin
                    add_st(1'b0, ta[i], td[i]);
                end else if (r < 26) begin
                    add_st(1'b1, ta[i], td[i] ^ (32'd1 << $urandom_range(0, 31)));
                end else begin
                    if (mode == 0 && cur < vl.size()) begin
                        i = vl[cur];
                        cur++;
                    end
                    add_st(1'b1, ta[i], td[i]);
                end
            end
        end
        run_test();
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_addr = 32'd0; cfg_data = 32'd0;
        start = 1'b0; clear = 1'b0; memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single entry matched on RUN cycle 5.
        clear_stim();
        tv[0] = 1'b1; ta[0] = 32'd84; td[0] = 32'h96;
        repeat (5) add_st(1'b0, 32'd0, 32'd0);
        add_st(1'b1, 32'd84, 32'h96);
        run_test();

        // Out-of-order stores with a stray store in between.
        clear_stim();
        tv[0] = 1'b1; ta[0] = 32'd84; td[0] = 32'h96;
        tv[1] = 1'b1; ta[1] = 32'd80; td[1] = 32'h7;
        add_st(1'b1, 32'd80, 32'h7);
        add_st(1'b1, 32'd60, 32'h1);
        add_st(1'b1, 32'd84, 32'h96);
        run_test();

        // Data mismatch.
        clear_stim();
        tv[0] = 1'b1; ta[0] = 32'd84; td[0] = 32'h96;
        add_st(1'b1, 32'd84, 32'h95);
        run_test();

        // Second entry stored first.
        clear_stim();
        tv[0] = 1'b1; ta[0] = 32'd80; td[0] = 32'd1;
        tv[1] = 1'b1; ta[1] = 32'd84; td[1] = 32'd2;
        add_st(1'b1, 32'd84, 32'd2);
        run_test();

        // Timeout, then a match on the very last RUN cycle.
        clear_stim();
        tv[2] = 1'b1; ta[2] = 32'd84; td[2] = 32'h96;
        run_test();
        clear_stim();
        tv[2] = 1'b1; ta[2] = 32'd84; td[2] = 32'h96;
        repeat (TO - 1) add_st(1'b0, 32'd84, 32'h96);
        add_st(1'b1, 32'd84, 32'h96);
        run_test();

        // Asynchronous reset in the middle of a run.
        clear_stim();
        @(negedge clk); cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 32'd84; cfg_data = 32'h96;
        @(negedge clk); cfg_we = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        #1 check_zero("async_reset");
        check("async_reset_pass0", {31'd0, pass[0]}, 32'd0);
        check("async_reset_fail1", {31'd0, fail[1]}, 32'd0);
        @(negedge clk); reset = 1'b1;
        // Empty table: start goes straight to PASS.
        clear_stim();
        run_test();

        for (int t = 0; t < 60; t++) random_test();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
